// File: rtl/core_pkg.sv
// Shared core types: datapath width, register-file geometry and ALU operation codes.
package core_pkg;

    localparam int XLEN       = 64;
    localparam int NREGS      = 32;
    localparam int REG_ADDR_W = 5;

    typedef logic [XLEN-1:0]       xlen_t;
    typedef logic [REG_ADDR_W-1:0] reg_addr_t;

    typedef enum logic [1:0] {
        ALU_AND = 2'b00,
        ALU_OR  = 2'b01,
        ALU_ADD = 2'b10,
        ALU_SUB = 2'b11
    } alu_code_t;

endpackage

// File: rtl/reg_file_64_if.sv
// Register-file access bundle: two read ports feeding the ALU and one writeback port.
interface reg_file_64_if;
    import core_pkg::*;

    reg_addr_t rs1_addr;
    reg_addr_t rs2_addr;
    xlen_t     rs1_data;
    xlen_t     rs2_data;
    logic      reg_write;
    reg_addr_t rd_addr;
    xlen_t     rd_data;

    modport master (
        output rs1_addr, rs2_addr, reg_write, rd_addr, rd_data,
        input  rs1_data, rs2_data
    );

    modport slave (
        input  rs1_addr, rs2_addr, reg_write, rd_addr, rd_data,
        output rs1_data, rs2_data
    );

endinterface

// File: rtl/reg_file_64_read_port.sv
// One combinational read port: x0 forcing, range check and, with REG_FILE_BYPASS_EN,
// write-through of the data being written this cycle.
module reg_read_port
    import core_pkg::*;
(
    input  xlen_t     regs [NREGS],
    input  reg_addr_t addr,
`ifdef REG_FILE_BYPASS_EN
    input  logic      wr_en,
    input  reg_addr_t wr_addr,
    input  xlen_t     wr_data,
`endif
    output xlen_t     data
);

    logic in_range;

    generate
        if (NREGS < (1 << REG_ADDR_W)) begin : g_range
            assign in_range = (32'(addr) < 32'(NREGS));
        end else begin : g_full
            assign in_range = 1'b1;
        end
    endgenerate

    always_comb begin
        data = '0;
        if ((addr != '0) && in_range) begin
            data = regs[addr];
        end
`ifdef REG_FILE_BYPASS_EN
        // wr_en already excludes x0, reset and out-of-range targets
        if (wr_en && (wr_addr == addr)) begin
            data = wr_data;
        end
`endif
    end

endmodule

// File: rtl/reg_file_64.sv
// 32 x 64-bit integer register file, x0 hardwired to zero, async active-low reset.
// Optional same-cycle write-through on the read ports: define REG_FILE_BYPASS_EN.
module reg_file_64
    import core_pkg::*;
(
    input  logic          clk,
    input  logic          rst_n,
    reg_file_64_if.slave  bus
);

    xlen_t regs [NREGS];
    logic  wr_in_range;
    logic  wr_en;

    generate
        if (NREGS < (1 << REG_ADDR_W)) begin : g_wr_range
            assign wr_in_range = (32'(bus.rd_addr) < 32'(NREGS));
        end else begin : g_wr_full
            assign wr_in_range = 1'b1;
        end
    endgenerate

    // rst_n gates the enable so a bypassed read also shows 0 while reset is held
    assign wr_en = rst_n & bus.reg_write & (bus.rd_addr != '0) & wr_in_range;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NREGS; i++) begin
                regs[i] <= '0;
            end
        end else if (wr_en) begin
            regs[bus.rd_addr] <= bus.rd_data;
        end
    end

    reg_read_port u_rs1 (
        .regs    (regs),
        .addr    (bus.rs1_addr),
`ifdef REG_FILE_BYPASS_EN
        .wr_en   (wr_en),
        .wr_addr (bus.rd_addr),
        .wr_data (bus.rd_data),
`endif
        .data    (bus.rs1_data)
    );

    reg_read_port u_rs2 (
        .regs    (regs),
        .addr    (bus.rs2_addr),
`ifdef REG_FILE_BYPASS_EN
        .wr_en   (wr_en),
        .wr_addr (bus.rd_addr),
        .wr_data (bus.rd_data),
`endif
        .data    (bus.rs2_data)
    );

endmodule

// File: tb/tb_reg_file_64.sv
// Directed and random checks of reg_file_64 against a reference array; expectations
// follow REG_FILE_BYPASS_EN when it is defined for the build.
module tb_reg_file_64;
    import core_pkg::*;

    logic clk;
    logic rst_n;
    int   checks;
    int   failures;

    xlen_t model [NREGS];

    reg_file_64_if bus ();

    reg_file_64 dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

`ifdef REG_FILE_BYPASS_EN
    localparam bit BYPASS = 1'b1;
`else
    localparam bit BYPASS = 1'b0;
`endif

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic wr(input reg_addr_t a, input xlen_t d);
        @(negedge clk);
        bus.reg_write = 1'b1;
        bus.rd_addr   = a;
        bus.rd_data   = d;
        @(negedge clk);
        bus.reg_write = 1'b0;
        if (a != '0) model[a] = d;
    endtask

    function automatic xlen_t expect_rd(input reg_addr_t a);
        xlen_t v;
        v = (a == '0) ? '0 : model[a];
        if (BYPASS && bus.reg_write && (bus.rd_addr != '0) && (bus.rd_addr == a))
            v = bus.rd_data;
        return v;
    endfunction

    initial begin
        xlen_t sum;
        checks   = 0;
        failures = 0;
        for (int i = 0; i < NREGS; i++) model[i] = '0;

        // Reset held with a write presented: write must be discarded
        rst_n         = 1'b0;
        bus.rs1_addr  = 5'd5;
        bus.rs2_addr  = 5'd5;
        bus.reg_write = 1'b1;
        bus.rd_addr   = 5'd5;
        bus.rd_data   = 64'hDEAD;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_rs1_x5", bus.rs1_data, 64'h0);
        chk("reset_rs2_x5", bus.rs2_data, 64'h0);
        @(negedge clk);
        bus.reg_write = 1'b0;
        rst_n         = 1'b1;
        for (int i = 0; i < NREGS; i++) begin
            bus.rs1_addr = reg_addr_t'(i);
            bus.rs2_addr = reg_addr_t'(NREGS - 1 - i);
            #1;
            chk("post_reset_rs1", bus.rs1_data, 64'h0);
            chk("post_reset_rs2", bus.rs2_data, 64'h0);
        end

        // Write/read, ALU ADD operands cancel
        wr(5'd3, 64'h0000_0000_0000_0007);
        wr(5'd4, 64'hFFFF_FFFF_FFFF_FFF9);
        bus.rs1_addr = 5'd3;
        bus.rs2_addr = 5'd4;
        #1;
        chk("rd_x3", bus.rs1_data, 64'h7);
        chk("rd_x4", bus.rs2_data, 64'hFFFF_FFFF_FFFF_FFF9);
        sum = bus.rs1_data + bus.rs2_data;
        chk("add_zero", sum, 64'h0);

        // x0 is never written
        wr(5'd0, 64'h1234);
        bus.rs1_addr = 5'd0;
        bus.rs2_addr = 5'd0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            #1;
            chk("x0_rs1", bus.rs1_data, 64'h0);
            chk("x0_rs2", bus.rs2_data, 64'h0);
        end

        // Same-cycle read and write of x9
        wr(5'd9, 64'h11);
        @(negedge clk);
        bus.rs1_addr  = 5'd9;
        bus.rs2_addr  = 5'd9;
        bus.reg_write = 1'b1;
        bus.rd_addr   = 5'd9;
        bus.rd_data   = 64'h22;
        #1;
        chk("rw_same_rs1", bus.rs1_data, BYPASS ? 64'h22 : 64'h11);
        chk("rw_same_rs2", bus.rs2_data, BYPASS ? 64'h22 : 64'h11);
        @(negedge clk);
        bus.reg_write = 1'b0;
        model[9]      = 64'h22;
        #1;
        chk("rw_next_rs1", bus.rs1_data, 64'h22);

        // Fill x1..x31, then an async reset pulse between edges
        for (int i = 1; i < NREGS; i++)
            wr(reg_addr_t'(i), {32'hA5A5_0000 | 32'(i), 32'(i) * 32'h0101_0101});
        bus.rs1_addr = 5'd31;
        bus.rs2_addr = 5'd17;
        #1;
        chk("fill_x31", bus.rs1_data, {32'hA5A5_001F, 32'h1F1F_1F1F});
        chk("fill_x17", bus.rs2_data, {32'hA5A5_0011, 32'h1111_1111});
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_rst_x31", bus.rs1_data, 64'h0);
        chk("async_rst_x17", bus.rs2_data, 64'h0);
        #1;
        rst_n = 1'b1;
        for (int i = 0; i < NREGS; i++) model[i] = '0;
        for (int i = 1; i < NREGS; i++) begin
            bus.rs1_addr = reg_addr_t'(i);
            #1;
            chk("after_pulse", bus.rs1_data, 64'h0);
        end

        // Random traffic against the reference array
        for (int n = 0; n < 10000; n++) begin
            @(negedge clk);
            bus.rs1_addr  = reg_addr_t'($urandom_range(0, NREGS - 1));
            bus.rs2_addr  = ($urandom_range(0, 7) == 0) ? bus.rs1_addr
                                                         : reg_addr_t'($urandom_range(0, NREGS - 1));
            bus.rd_addr   = ($urandom_range(0, 3) == 0) ? bus.rs1_addr
                                                         : reg_addr_t'($urandom_range(0, NREGS - 1));
            bus.rd_data   = {$urandom, $urandom};
            bus.reg_write = 1'($urandom_range(0, 1));
            #1;
            chk("rand_rs1", bus.rs1_data, expect_rd(bus.rs1_addr));
            chk("rand_rs2", bus.rs2_data, expect_rd(bus.rs2_addr));
            if (bus.reg_write && (bus.rd_addr != '0)) model[bus.rd_addr] = bus.rd_data;
        end
        @(negedge clk);
        bus.reg_write = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
